// File: rtl/cs_address_sequencer.sv
// Control-store address sequencer: holds the current microinstruction address and
// selects the next one (increment, flag/IR branch, opcode decode), stalling on memory access.
module cs_address_sequencer #(
    parameter int unsigned DATAWIDTH_JUMPADDRESS = 11,
    parameter int unsigned DATAWIDTH_CONDITION   = 3,
    parameter int unsigned DATAWIDTH_IR          = 32,
    parameter logic [DATAWIDTH_JUMPADDRESS-1:0] RESET_ADDRESS = 11'd0,
    parameter logic [DATAWIDTH_JUMPADDRESS-1:0] TRAP_ADDRESS  = 11'd2046,
    parameter int unsigned TIMEOUT_CYCLES        = 16,
    parameter int unsigned TIMER_WIDTH           = 5
) (
    input  logic                             CS_ADDRESS_SEQUENCER_CLOCK_50,
    input  logic                             CS_ADDRESS_SEQUENCER_ResetInHigh_In,
    input  logic [DATAWIDTH_CONDITION-1:0]   CS_ADDRESS_SEQUENCER_Condition_InBus,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_JumpAddress_InBus,
    input  logic                             CS_ADDRESS_SEQUENCER_RD_In,
    input  logic                             CS_ADDRESS_SEQUENCER_WRMain_In,
    input  logic                             CS_ADDRESS_SEQUENCER_MemAck_In,
    input  logic [3:0]                       CS_ADDRESS_SEQUENCER_PSR_InBus,
    input  logic [DATAWIDTH_IR-1:0]          CS_ADDRESS_SEQUENCER_IR_InBus,
    output logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_CSAddress_OutBus,
    output logic                             CS_ADDRESS_SEQUENCER_Advance_Out,
    output logic                             CS_ADDRESS_SEQUENCER_MemWait_Out,
    output logic                             CS_ADDRESS_SEQUENCER_Timeout_Out
);

    localparam logic [DATAWIDTH_CONDITION-1:0] CondInc    = 3'b000;
    localparam logic [DATAWIDTH_CONDITION-1:0] CondN      = 3'b001;
    localparam logic [DATAWIDTH_CONDITION-1:0] CondZ      = 3'b010;
    localparam logic [DATAWIDTH_CONDITION-1:0] CondV      = 3'b011;
    localparam logic [DATAWIDTH_CONDITION-1:0] CondC      = 3'b100;
    localparam logic [DATAWIDTH_CONDITION-1:0] CondIr13   = 3'b101;
    localparam logic [DATAWIDTH_CONDITION-1:0] CondJump   = 3'b110;
    localparam logic [DATAWIDTH_CONDITION-1:0] CondDecode = 3'b111;

    localparam logic [DATAWIDTH_JUMPADDRESS-1:0] AddrOne   = 1;
    localparam logic [TIMER_WIDTH-1:0]           TimerOne  = 1;
    localparam logic [TIMER_WIDTH-1:0]           TimerLast = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        StRun,
        StWait
    } state_e;

    state_e                           state_q, state_d;
    logic [DATAWIDTH_JUMPADDRESS-1:0] addr_q, addr_d;
    logic [TIMER_WIDTH-1:0]           timer_q, timer_d;
    logic                             timeout_q, timeout_d;
    logic                             mem_wait_q, mem_wait_d;
    logic                             advance;

    logic [DATAWIDTH_JUMPADDRESS-1:0] inc_addr;
    logic [DATAWIDTH_JUMPADDRESS-1:0] jump_addr;
    logic [DATAWIDTH_JUMPADDRESS-1:0] decode_addr;
    logic [DATAWIDTH_JUMPADDRESS-1:0] next_addr;
    logic [10:0]                      decode_raw;
    logic                             flag_n, flag_z, flag_v, flag_c;
    logic                             mem_req;
    logic                             mem_ack;
    logic                             unused_ir;

    assign flag_n  = CS_ADDRESS_SEQUENCER_PSR_InBus[3];
    assign flag_z  = CS_ADDRESS_SEQUENCER_PSR_InBus[2];
    assign flag_v  = CS_ADDRESS_SEQUENCER_PSR_InBus[1];
    assign flag_c  = CS_ADDRESS_SEQUENCER_PSR_InBus[0];
    assign mem_req = CS_ADDRESS_SEQUENCER_RD_In | CS_ADDRESS_SEQUENCER_WRMain_In;
    assign mem_ack = CS_ADDRESS_SEQUENCER_MemAck_In;

    assign inc_addr  = addr_q + AddrOne;
    assign jump_addr = CS_ADDRESS_SEQUENCER_JumpAddress_InBus;

    // Opcode dispatch: op (IR[31:30]) and op3 (IR[24:19]) pick a 4-word slot in the upper half.
    assign decode_raw  = {1'b1, CS_ADDRESS_SEQUENCER_IR_InBus[31:30],
                          CS_ADDRESS_SEQUENCER_IR_InBus[24:19], 2'b00};
    assign decode_addr = DATAWIDTH_JUMPADDRESS'(decode_raw);

    assign unused_ir = ^{CS_ADDRESS_SEQUENCER_IR_InBus[29:25], CS_ADDRESS_SEQUENCER_IR_InBus[18:14],
                         CS_ADDRESS_SEQUENCER_IR_InBus[12:0]};

    always_comb begin
        next_addr = inc_addr;
        case (CS_ADDRESS_SEQUENCER_Condition_InBus)
            CondInc:    next_addr = inc_addr;
            CondN:      next_addr = flag_n ? jump_addr : inc_addr;
            CondZ:      next_addr = flag_z ? jump_addr : inc_addr;
            CondV:      next_addr = flag_v ? jump_addr : inc_addr;
            CondC:      next_addr = flag_c ? jump_addr : inc_addr;
            CondIr13:   next_addr = CS_ADDRESS_SEQUENCER_IR_InBus[13] ? jump_addr : inc_addr;
            CondJump:   next_addr = jump_addr;
            CondDecode: next_addr = decode_addr;
            default:    next_addr = inc_addr;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        advance   = 1'b0;
        case (state_q)
            StRun: begin
                if (!mem_req || mem_ack) begin
                    addr_d  = next_addr;
                    advance = 1'b1;
                end else begin
                    // The issuing cycle already counts toward the timeout.
                    timer_d = TimerOne;
                    state_d = StWait;
                end
            end
            StWait: begin
                // An ack in the final cycle beats the trap.
                if (mem_ack) begin
                    addr_d  = next_addr;
                    advance = 1'b1;
                    timer_d = '0;
                    state_d = StRun;
                end else if (timer_q == TimerLast) begin
                    addr_d    = TRAP_ADDRESS;
                    timeout_d = 1'b1;
                    timer_d   = '0;
                    state_d   = StRun;
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
            default: begin
                state_d = StRun;
                timer_d = '0;
            end
        endcase
        mem_wait_d = (state_d == StWait);
    end

    always_ff @(posedge CS_ADDRESS_SEQUENCER_CLOCK_50) begin
        if (CS_ADDRESS_SEQUENCER_ResetInHigh_In) begin
            state_q    <= StRun;
            addr_q     <= RESET_ADDRESS;
            timer_q    <= '0;
            timeout_q  <= 1'b0;
            mem_wait_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            timer_q    <= timer_d;
            timeout_q  <= timeout_d;
            mem_wait_q <= mem_wait_d;
        end
    end

    assign CS_ADDRESS_SEQUENCER_CSAddress_OutBus = addr_q;
    assign CS_ADDRESS_SEQUENCER_Advance_Out      = advance;
    assign CS_ADDRESS_SEQUENCER_MemWait_Out      = mem_wait_q;
    assign CS_ADDRESS_SEQUENCER_Timeout_Out      = timeout_q;

endmodule

// File: tb/tb_cs_address_sequencer.sv
// Bench for cs_address_sequencer: vector table for next-address selection plus
// hand-written stall, timeout and reset-during-wait sequences.
module tb_cs_address_sequencer;

    logic        clk;
    logic        rst_s;
    logic [2:0]  cond_s;
    logic [10:0] jump_s;
    logic        rd_s;
    logic        wr_s;
    logic        ack_s;
    logic [3:0]  psr_s;
    logic [31:0] ir_s;
    logic [10:0] addr_o;
    logic        adv_o;
    logic        mw_o;
    logic        to_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [10:0] addr;
        logic        mw;
        logic        to;
    } exp_t;

    exp_t sb[$];

    typedef struct packed {
        logic [2:0]  cond;
        logic [10:0] jump;
        logic [3:0]  psr;
        logic [31:0] ir;
        logic        rd;
        logic        wr;
        logic        ack;
        logic [10:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    cs_address_sequencer dut (
        .CS_ADDRESS_SEQUENCER_CLOCK_50         (clk),
        .CS_ADDRESS_SEQUENCER_ResetInHigh_In   (rst_s),
        .CS_ADDRESS_SEQUENCER_Condition_InBus  (cond_s),
        .CS_ADDRESS_SEQUENCER_JumpAddress_InBus(jump_s),
        .CS_ADDRESS_SEQUENCER_RD_In            (rd_s),
        .CS_ADDRESS_SEQUENCER_WRMain_In        (wr_s),
        .CS_ADDRESS_SEQUENCER_MemAck_In        (ack_s),
        .CS_ADDRESS_SEQUENCER_PSR_InBus        (psr_s),
        .CS_ADDRESS_SEQUENCER_IR_InBus         (ir_s),
        .CS_ADDRESS_SEQUENCER_CSAddress_OutBus (addr_o),
        .CS_ADDRESS_SEQUENCER_Advance_Out      (adv_o),
        .CS_ADDRESS_SEQUENCER_MemWait_Out      (mw_o),
        .CS_ADDRESS_SEQUENCER_Timeout_Out      (to_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entered 1 time unit after a rising edge; drives one cycle, checks the combinational
    // outputs at the falling edge and the registered ones just after the next rising edge.
    task automatic step(input string tag, input logic rst, input logic [2:0] cond,
                        input logic [10:0] jump, input logic [3:0] psr, input logic [31:0] ir,
                        input logic rd, input logic wr, input logic ack,
                        input logic chk_pre, input logic exp_adv, input logic exp_mw_pre,
                        input logic [10:0] exp_addr, input logic exp_mw, input logic exp_to);
        exp_t e;
        rst_s  = rst;
        cond_s = cond;
        jump_s = jump;
        psr_s  = psr;
        ir_s   = ir;
        rd_s   = rd;
        wr_s   = wr;
        ack_s  = ack;
        e.addr = exp_addr;
        e.mw   = exp_mw;
        e.to   = exp_to;
        sb.push_back(e);
        #4;
        if (chk_pre) begin
            check({tag, " advance"}, 32'(adv_o), 32'(exp_adv));
            check({tag, " memwait_pre"}, 32'(mw_o), 32'(exp_mw_pre));
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " csaddress"}, 32'(addr_o), 32'(e.addr));
            check({tag, " memwait"}, 32'(mw_o), 32'(e.mw));
            check({tag, " timeout"}, 32'(to_o), 32'(e.to));
        end
    endtask

    // Up to 16 cycles of a held memory request; ack arrives at cycle ack_at, reset at rst_at.
    task automatic mem_seq(input string tag, input logic rd, input logic wr, input logic [2:0] cond,
                           input logic [10:0] jump, input logic [10:0] start,
                           input logic [10:0] nxt, input int ack_at, input int rst_at,
                           input logic to_in);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (!done) begin
                if (k == rst_at) begin
                    step($sformatf("%s c%0d", tag, k), 1'b1, cond, jump, 4'h0, 32'h0, rd, wr,
                         1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);
                    done = 1'b1;
                end else if (k == ack_at) begin
                    step($sformatf("%s c%0d", tag, k), 1'b0, cond, jump, 4'h0, 32'h0, rd, wr,
                         1'b1, 1'b1, 1'b1, (k > 0), nxt, 1'b0, to_in);
                    done = 1'b1;
                end else if (k == 15) begin
                    step($sformatf("%s c%0d", tag, k), 1'b0, cond, jump, 4'h0, 32'h0, rd, wr,
                         1'b0, 1'b1, 1'b0, 1'b1, 11'd2046, 1'b0, 1'b1);
                    done = 1'b1;
                end else begin
                    step($sformatf("%s c%0d", tag, k), 1'b0, cond, jump, 4'h0, 32'h0, rd, wr,
                         1'b0, 1'b1, 1'b0, (k > 0), start, 1'b1, to_in);
                end
            end
        end
    endtask

    initial begin
        //              cond    jump    psr      ir            rd wr ack exp
        vecs.push_back({3'b000, 11'd1234, 4'hF, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 11'd1});
        vecs.push_back({3'b111, 11'd7,    4'h0, 32'h8080_0000, 1'b0, 1'b0, 1'b0, 11'd1600});
        vecs.push_back({3'b101, 11'd1602, 4'hF, 32'hFFFF_DFFF, 1'b0, 1'b0, 1'b0, 11'd1601});
        vecs.push_back({3'b111, 11'd0,    4'h0, 32'h8080_0000, 1'b0, 1'b0, 1'b0, 11'd1600});
        vecs.push_back({3'b101, 11'd1602, 4'h0, 32'h0000_2000, 1'b0, 1'b0, 1'b0, 11'd1602});
        vecs.push_back({3'b111, 11'd3,    4'h0, 32'h80A0_2000, 1'b0, 1'b0, 1'b0, 11'd1616});
        vecs.push_back({3'b010, 11'd5,    4'h4, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 11'd5});
        vecs.push_back({3'b010, 11'd77,   4'hB, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 11'd6});
        vecs.push_back({3'b001, 11'd100,  4'h8, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 11'd100});
        vecs.push_back({3'b001, 11'd200,  4'h7, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 11'd101});
        vecs.push_back({3'b011, 11'd300,  4'h2, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 11'd300});
        vecs.push_back({3'b011, 11'd400,  4'hD, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 11'd301});
        vecs.push_back({3'b100, 11'd2047, 4'h1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 11'd2047});
        vecs.push_back({3'b000, 11'd55,   4'h0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 11'd0});
        vecs.push_back({3'b100, 11'd9,    4'hE, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 11'd1});
        vecs.push_back({3'b110, 11'd2047, 4'h0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 11'd2047});
        vecs.push_back({3'b111, 11'd0,    4'h0, 32'h4080_0000, 1'b0, 1'b0, 1'b0, 11'd1344});
        vecs.push_back({3'b000, 11'd0,    4'h0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 11'd1345});
        vecs.push_back({3'b110, 11'd500,  4'h0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 11'd500});
        vecs.push_back({3'b000, 11'd0,    4'h0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 11'd501});

        rst_s  = 1'b1;
        cond_s = 3'b000;
        jump_s = 11'd0;
        psr_s  = 4'h0;
        ir_s   = 32'h0;
        rd_s   = 1'b0;
        wr_s   = 1'b0;
        ack_s  = 1'b0;
        @(posedge clk);
        #1;

        // Reset with random microinstruction fields
        for (int r = 0; r < 2; r++) begin
            step($sformatf("reset%0d", r), 1'b1, 3'($urandom()), 11'($urandom()),
                 4'($urandom()), $urandom(), 1'($urandom()), 1'($urandom()), 1'($urandom()),
                 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);
        end

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), 1'b0, vecs[i].cond, vecs[i].jump, vecs[i].psr,
                 vecs[i].ir, vecs[i].rd, vecs[i].wr, vecs[i].ack,
                 1'b1, 1'b1, 1'b0, vecs[i].exp_addr, 1'b0, 1'b0);
        end

        step("rst_a", 1'b1, 3'b000, 11'd0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);
        mem_seq("stall", 1'b1, 1'b0, 3'b110, 11'd42, 11'd0, 11'd42, 3, 99, 1'b0);
        mem_seq("trap", 1'b1, 1'b0, 3'b000, 11'd0, 11'd42, 11'd43, 99, 99, 1'b0);
        step("after_trap", 1'b0, 3'b000, 11'd0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b1, 1'b1, 1'b0, 11'd2047, 1'b0, 1'b1);
        step("wrap", 1'b0, 3'b000, 11'd0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b1, 1'b1, 1'b0, 11'd0, 1'b0, 1'b1);
        mem_seq("ack16", 1'b0, 1'b1, 3'b110, 11'd123, 11'd0, 11'd123, 15, 99, 1'b1);
        mem_seq("retrap", 1'b1, 1'b0, 3'b000, 11'd0, 11'd123, 11'd124, 99, 99, 1'b1);
        mem_seq("rst_wait", 1'b1, 1'b0, 3'b000, 11'd0, 11'd2046, 11'd2047, 99, 5, 1'b1);
        mem_seq("post_rst", 1'b1, 1'b0, 3'b110, 11'd9, 11'd0, 11'd9, 99, 99, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
